icache_set_assoc: RTL and testbench

ICACHE_SET_ASSOC -- requirements
Module: icache_set_assoc

---
 rtl/icache_set_assoc_pkg.sv | 10 +
 rtl/icache_set_assoc_way.sv | 49 ++++
 rtl/icache_set_assoc.sv | 174 +++++++++++++++++
 tb/tb_icache_set_assoc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_set_assoc_pkg.sv
// Shared defaults and FSM encodings for the set-associative instruction cache.
package icache_set_assoc_pkg;
  localparam int ICACHE_WAYS     = 2;
  localparam int ICACHE_SET_BIT  = 4;
  localparam int ICACHE_LINE_BIT = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/icache_set_assoc_way.sv
// One cache way: per-set valid bits, tag and line storage, and the hit compare.
module icache_way
  import icache_set_assoc_pkg::*;
#(
  parameter int SET_BIT  = ICACHE_SET_BIT,
  parameter int LINE_BIT = ICACHE_LINE_BIT,
  parameter int TAG_BIT  = 32 - 2 - ICACHE_LINE_BIT - ICACHE_SET_BIT
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          clear_all,
  input  logic                          fill_en,
  input  logic [SET_BIT-1:0]            fill_set,
  input  logic [TAG_BIT-1:0]            fill_tag,
  input  logic [(32<<LINE_BIT)-1:0]     fill_line,
  input  logic [SET_BIT-1:0]            lkp_set,
  input  logic [TAG_BIT-1:0]            lkp_tag,
  input  logic [LINE_BIT-1:0]           lkp_word,
  output logic                          hit,
  output logic [31:0]                   hit_data,
  input  logic [SET_BIT-1:0]            vic_set,
  output logic                          vic_valid
);
  localparam int SETS  = 1 << SET_BIT;
  localparam int WORDS = 1 << LINE_BIT;

  logic [SETS-1:0]    valid_reg;
  logic [TAG_BIT-1:0] tag_mem  [SETS];
  logic [31:0]        data_mem [SETS*WORDS];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)        valid_reg <= '0;
    else if (clear_all) valid_reg <= '0;
    else if (fill_en)   valid_reg[fill_set] <= 1'b1;
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_set] <= fill_tag;
      for (int w = 0; w < WORDS; w++)
        data_mem[{fill_set, LINE_BIT'(w)}] <= fill_line[w*32 +: 32];
    end
  end

  assign hit       = valid_reg[lkp_set] && (tag_mem[lkp_set] == lkp_tag);
  assign hit_data  = data_mem[{lkp_set, lkp_word}];
  assign vic_valid = valid_reg[vic_set];
endmodule

// File: rtl/icache_set_assoc.sv
// Blocking set-associative instruction cache with word-serial line refill.
module icache_set_assoc
  import icache_set_assoc_pkg::*;
#(
  parameter int WAYS     = ICACHE_WAYS,
  parameter int SET_BIT  = ICACHE_SET_BIT,
  parameter int LINE_BIT = ICACHE_LINE_BIT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int WORDS   = 1 << LINE_BIT;
  localparam int SETS    = 1 << SET_BIT;
  localparam int OFF     = 2 + LINE_BIT;
  localparam int TAG_BIT = 32 - OFF - SET_BIT;
  localparam int RR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [1:0]             state_reg;
  logic [LINE_BIT-1:0]    cnt_reg;
  logic [31:2]            addr_reg;
  logic                   flush_pend_reg;
  logic [WORDS-1:0][31:0] line_buf_reg;
  logic [WORDS-1:0][31:0] fill_line;

  logic [SET_BIT-1:0]  req_set, addr_set;
  logic [TAG_BIT-1:0]  req_tag, addr_tag;
  logic [LINE_BIT-1:0] req_word, addr_word;
  assign req_set   = req_addr[OFF+SET_BIT-1:OFF];
  assign req_tag   = req_addr[31:OFF+SET_BIT];
  assign req_word  = req_addr[OFF-1:2];
  assign addr_set  = addr_reg[OFF+SET_BIT-1:OFF];
  assign addr_tag  = addr_reg[31:OFF+SET_BIT];
  assign addr_word = addr_reg[OFF-1:2];

  logic [WAYS-1:0] hit_vec, vic_valid_vec, fill_en_vec;
  logic [31:0]     way_data [WAYS];
  logic [RR_W-1:0] victim, rr_cur;
  logic            hit_any, victim_found;
  logic [31:0]     hit_data;
  logic            accept, last_ack, flush_eff, fill_go, clear_all;

  assign req_ready = (state_reg == ST_IDLE) && !flush;
  assign accept    = rdy_in && req_valid && req_ready;
  assign last_ack  = (state_reg == ST_REFILL) && mem_ack && (cnt_reg == LINE_BIT'(WORDS - 1));
  assign flush_eff = flush_pend_reg || flush;
  // A flush seen anywhere in the refill suppresses the install but not the response.
  assign fill_go   = rdy_in && last_ack && !flush_eff;
  assign clear_all = rdy_in && (((state_reg == ST_IDLE) && flush) ||
                                ((state_reg == ST_RESP) && flush_eff));

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign fill_en_vec[gi] = fill_go && (victim == RR_W'(gi));
    icache_way #(.SET_BIT(SET_BIT), .LINE_BIT(LINE_BIT), .TAG_BIT(TAG_BIT)) u_way (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_all (clear_all),
      .fill_en   (fill_en_vec[gi]),
      .fill_set  (addr_set),
      .fill_tag  (addr_tag),
      .fill_line (fill_line),
      .lkp_set   (req_set),
      .lkp_tag   (req_tag),
      .lkp_word  (req_word),
      .hit       (hit_vec[gi]),
      .hit_data  (way_data[gi]),
      .vic_set   (addr_set),
      .vic_valid (vic_valid_vec[gi])
    );
  end

  if (WAYS > 1) begin : g_rr
    logic [SETS-1:0][RR_W-1:0] rr_reg;
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
        rr_reg <= '0;
      else if (fill_go)
        rr_reg[addr_set] <= (rr_reg[addr_set] == RR_W'(WAYS - 1)) ? '0 : rr_reg[addr_set] + RR_W'(1);
    end
    assign rr_cur = rr_reg[addr_set];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  always_comb begin
    victim       = rr_cur;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !vic_valid_vec[w]) begin
        victim       = RR_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    hit_any  = |hit_vec;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_data = hit_data | way_data[w];
  end

  // The last word bypasses the buffer so the line is complete on its ack edge.
  always_comb begin
    fill_line          = line_buf_reg;
    fill_line[cnt_reg] = mem_data;
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && (state_reg == ST_REFILL) && mem_ack)
      line_buf_reg[cnt_reg] <= mem_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      flush_pend_reg <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
    end else if (rdy_in) begin
      case (state_reg)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            if (hit_any) begin
              resp_valid <= 1'b1;
              resp_data  <= hit_data;
            end else begin
              addr_reg  <= req_addr[31:2];
              cnt_reg   <= '0;
              mem_req   <= 1'b1;
              mem_addr  <= req_addr & ~32'(WORDS*4 - 1);
              state_reg <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (mem_ack) begin
            cnt_reg <= cnt_reg + LINE_BIT'(1);
            if (last_ack) begin
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_data  <= fill_line[addr_word];
              state_reg  <= ST_RESP;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        ST_RESP: begin
          resp_valid     <= 1'b0;
          flush_pend_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_set_assoc.sv
// Randomized scoreboard bench for icache_set_assoc against a behavioural cache model.
module tb_icache_set_assoc;
  localparam int WAYS  = 2;
  localparam int SETS  = 16;
  localparam int WORDS = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;

  always #5 clk_in = ~clk_in;

  icache_set_assoc dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  typedef struct { logic [31:0] data; int acks; } sb_t;
  sb_t         sb_q [$];
  logic [31:0] mem_q [$];

  int checks = 0, errors = 0;
  int acks_total = 0, last_acks = 0;
  bit in_reset = 1'b1, rdy_en = 1'b0;

  // Reference model: per-way valid/tag per set plus the round-robin pointers.
  bit          m_valid [WAYS][SETS];
  logic [23:0] m_tag   [WAYS][SETS];
  int          m_rr    [SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'(a[7:4]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][s] && m_tag[w][s] == a[31:8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_install(input logic [31:0] a);
    int s = int'(a[7:4]);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[w][s]) v = w;
    if (v < 0) v = m_rr[s];
    m_valid[v][s] = 1'b1;
    m_tag[v][s]   = a[31:8];
    m_rr[s]       = (m_rr[s] + 1) % WAYS;
  endtask

  // Memory responder: checks each requested word address in order, acks randomly.
  initial begin
    forever begin
      @(negedge clk_in);
      mem_ack = 1'b0;
      if (!in_reset && mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
          chk("mem_addr", mem_addr, mem_q[0]);
          if (rdy_in) begin
            if ($urandom_range(0, 99) < 70) begin
              mem_ack  = 1'b1;
              mem_data = mem_word(mem_q[0]);
              void'(mem_q.pop_front());
              acks_total++;
            end
          end else begin
            mem_ack  = 1'($urandom_range(0, 1));
            mem_data = $urandom;
          end
        end
      end
    end
  end

  // Response monitor: a response counts once, on the cycle it completes with rdy_in high.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk_in);
      if (!in_reset && resp_valid && rdy_in) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("acks_per_txn", acks_total - last_acks, e.acks);
          last_acks = acks_total;
        end
      end
    end
  end

  // Random global-stall bursts of 1..3 cycles.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (rdy_en && $urandom_range(0, 7) == 0) begin
        rdy_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
      end
    end
  end

  // fmode: 0 plain, 1 flush together with the request in IDLE, 2 flush during a refill.
  task automatic do_req(input logic [31:0] a, input int fmode);
    bit hit, acc, was_rdy;
    int n, base;
    sb_t e;
    @(posedge clk_in);
    #1;
    if (fmode == 1) begin
      flush = 1'b1; req_valid = 1'b1; req_addr = a;
      @(negedge clk_in);
      chk("req_ready_flush", {31'd0, req_ready}, 32'd0);
      was_rdy = rdy_in;
      @(posedge clk_in);
      #1;
      flush = 1'b0;
      if (was_rdy) model_clear();
    end
    req_valid = 1'b1; req_addr = a; acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk_in);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      if (rdy_in && req_ready) acc = 1'b1;
      else begin
        @(posedge clk_in);
        #1;
        n++;
      end
    end
    if (!acc) begin
      fail_timeout("accept");
      req_valid = 1'b0;
      return;
    end
    hit = model_hit(a);
    e.data = mem_word(a);
    e.acks = hit ? 0 : WORDS;
    sb_q.push_back(e);
    if (!hit) begin
      for (int i = 0; i < WORDS; i++) mem_q.push_back({a[31:4], 4'h0} + 32'(4*i));
      if (fmode != 2) model_install(a);
    end
    @(posedge clk_in);
    #1;
    req_valid = 1'b0;
    base = acks_total;
    if (!hit && fmode == 2) flush = 1'b1;
    @(negedge clk_in);
    chk("resp_valid_after_accept", {31'd0, resp_valid}, {31'd0, hit});
    chk("mem_req_after_accept", {31'd0, mem_req}, {31'd0, !hit});
    if (!hit && fmode == 2) begin
      n = 0;
      while (acks_total - base < 2 && n < 100) begin
        @(posedge clk_in);
        #1;
        n++;
      end
      if (n >= 100) fail_timeout("flush_refill_acks");
      flush = 1'b0;
    end
    n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 300) begin
      fail_timeout("response");
      sb_q.delete();
      mem_q.delete();
    end
    if (!hit && fmode == 2) model_clear();
  endtask

  initial begin
    int r, fm;
    logic [31:0] a;
    model_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    #2;
    rst_in = 1'b1;
    in_reset = 1'b0;

    // Cold miss then hit, conflict eviction, flush cases.
    do_req(32'h0000_1004, 0);
    do_req(32'h0000_100C, 0);
    do_req(32'h0000_2000, 0);
    do_req(32'h0000_3000, 0);
    do_req(32'h0000_2000, 0);
    do_req(32'h0000_1000, 0);
    do_req(32'h0000_3004, 0);
    do_req(32'h0000_1004, 1);
    do_req(32'h0000_2008, 1);
    do_req(32'h0000_1000, 2);
    do_req(32'h0000_1000, 0);
    do_req(32'h0000_1008, 0);

    rdy_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      a  = 32'($urandom_range(1, 3)) * 32'h1000 + 32'($urandom_range(0, 2)) * 16
         + 32'($urandom_range(0, 3)) * 4;
      r  = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_req(a, fm);
    end

    // Asynchronous reset in the middle of a refill.
    rdy_en = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    req_valid = 1'b1; req_addr = 32'h0000_7000;
    for (int i = 0; i < WORDS; i++) mem_q.push_back(32'h0000_7000 + 32'(4*i));
    @(posedge clk_in);
    #1;
    req_valid = 1'b0;
    @(negedge clk_in);
    chk("prerst_mem_req", {31'd0, mem_req}, 32'd1);
    #2;
    in_reset = 1'b1;
    rst_in = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    mem_q.delete();
    sb_q.delete();
    model_reset();
    mem_ack = 1'b0;
    repeat (2) @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    last_acks = acks_total;
    in_reset = 1'b0;
    @(negedge clk_in);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    do_req(32'h0000_1000, 0);
    do_req(32'h0000_2004, 0);
    do_req(32'h0000_1008, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
